// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_e;

   localparam int WIDTH_DEFAULT     = 8;
   localparam int MSB_FIRST_DEFAULT = 1;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking the bits left in the current word.
module piso_bit_counter #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          zero_o
);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Valid/ready word intake, shifted out one bit per clock; a word accepted on
// the last bit of the previous one follows with no idle gap.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEFAULT,
   parameter int MSB_FIRST = MSB_FIRST_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             last_bit
);

   localparam int CW = $clog2(WIDTH);

   piso_state_e      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             first_q, first_d;
   logic             cnt_load, cnt_en, cnt_zero;
   logic [CW-1:0]    cnt_val;
   logic             accept;

   piso_bit_counter #(.CW(CW)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (CW'(WIDTH - 1)),
      .en_i       (cnt_en),
      .count_o    (cnt_val),
      .zero_o     (cnt_zero)
   );

   assign in_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && cnt_zero));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      first_d  = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      if (accept) begin
         // Covers both IDLE pickup and the gapless reload on the last bit.
         state_d  = SHIFT;
         shreg_d  = in_data;
         cnt_load = 1'b1;
         first_d  = 1'b1;
      end else begin
         case (state_q)
            SHIFT: begin
               if (cnt_zero) begin
                  state_d = IDLE;
                  shreg_d = '0;
               end else begin
                  cnt_en  = 1'b1;
                  shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                             : {1'b0, shreg_q[WIDTH-1:1]};
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         first_q <= first_d;
      end
   end

   // Outputs come straight from registered state so they carry no input paths.
   assign ser_valid   = (state_q == SHIFT);
   assign ser_out     = ser_valid && ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);
   assign frame_start = first_q;
   assign last_bit    = ser_valid && cnt_zero;

   logic unused_cnt;
   assign unused_cnt = ^cnt_val;

endmodule
